// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
// Holds the PC and keeps at most one request outstanding to instruction memory.
// Each fetched word goes through a one-entry output buffer to decode.
// A taken branch redirects the PC and squashes any fetch still in flight.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_INC   = 32'd4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [5:0]        if_op,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4
);

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic              drop_q;
  logic              if_valid_q;
  logic [31:0]       if_instr_q;
  logic [ADDR_W-1:0] if_pc_q;
  logic [ADDR_W-1:0] if_pc_plus4_q;
  logic [ADDR_W-1:0] branch_pc;

  // Redirect targets are always word aligned; the low two bits are discarded.
  assign branch_pc = branch_target & ALIGN_MASK;

  // Fetch control FSM together with the PC, the squash flag and the output buffer.
  // In every state a taken branch is checked first, so it overrides all handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      req_pc_q      <= RESET_PC;
      drop_q        <= 1'b0;
      if_valid_q    <= 1'b0;
      if_instr_q    <= 32'd0;
      if_pc_q       <= '0;
      if_pc_plus4_q <= '0;
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q <= S_REQ;
          if (branch_taken) begin
            pc_q <= branch_pc;
          end
        end
        S_REQ: begin
          if (branch_taken) begin
            pc_q <= branch_pc;
            if (imem_req_ready) begin
              // The request accepted this cycle is for the old path, so its response is discarded.
              drop_q  <= 1'b1;
              state_q <= S_WAIT;
            end
          end else if (imem_req_ready) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + PC_STEP;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (drop_q || branch_taken) begin
              drop_q  <= 1'b0;
              state_q <= S_REQ;
              if (branch_taken) begin
                pc_q <= branch_pc;
              end
            end else begin
              if_instr_q    <= imem_resp_data;
              if_pc_q       <= req_pc_q;
              if_pc_plus4_q <= req_pc_q + PC_STEP;
              if_valid_q    <= 1'b1;
              state_q       <= S_HOLD;
            end
          end else if (branch_taken) begin
            pc_q   <= branch_pc;
            drop_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (branch_taken) begin
            // Flush: the buffered instruction is on the wrong path and is never handed to decode.
            if_valid_q <= 1'b0;
            pc_q       <= branch_pc;
            state_q    <= S_REQ;
          end else if (if_valid_q && if_ready) begin
            if_valid_q <= 1'b0;
            state_q    <= S_REQ;
          end
        end
        default: begin
          state_q    <= S_BOOT;
          drop_q     <= 1'b0;
          if_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign if_valid       = if_valid_q;
  assign if_instr       = if_instr_q;
  assign if_op          = if_instr_q[31:26];
  assign if_pc          = if_pc_q;
  assign if_pc_plus4    = if_pc_plus4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// It contains a variable-latency memory model and a scoreboard of expected
// deliveries, and it runs directed corner-case sequences followed by a table
// of redirect/fetch vectors.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [5:0]  if_op;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .PC_INC(32'd4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_op(if_op), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
  } sb_t;
  sb_t sb[$];

  logic [31:0] mem [logic [31:0]];
  int          lat;
  int          pend_cnt;
  logic        pend_busy;
  logic        pend_stale;
  logic [31:0] pend_addr;

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [31:0] instr;
    int          lat;
    int          hold;
    logic [5:0]  op;
    logic [31:0] pc4;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    else return {16'hA5A5, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: evaluate the handshakes that complete at the coming edge, then advance the memory model.
  task automatic cyc();
    sb_t e;
    if (!rst) begin
      if (pend_busy && branch_taken) pend_stale = 1'b1;
      if (imem_resp_valid) begin
        if (!pend_stale) begin
          e.pc = pend_addr; e.instr = mem_rd(pend_addr); e.pc4 = pend_addr + 32'd4;
          sb.push_back(e);
        end
        pend_busy = 1'b0;
        pend_stale = 1'b0;
      end
      if (imem_req_valid && imem_req_ready) begin
        pend_busy = 1'b1; pend_stale = branch_taken; pend_addr = imem_req_addr; pend_cnt = lat;
      end
      if (if_valid && branch_taken) begin
        if (sb.size() == 0) chk("sb_flush_nonempty", 64'(sb.size()), 64'd1);
        else void'(sb.pop_front());
      end else if (if_valid && if_ready) begin
        if (sb.size() == 0) chk("sb_out_nonempty", 64'(sb.size()), 64'd1);
        else begin
          e = sb.pop_front();
          chk("sb_instr", 64'(if_instr), 64'(e.instr));
          chk("sb_pc", 64'(if_pc), 64'(e.pc));
          chk("sb_pc4", 64'(if_pc_plus4), 64'(e.pc4));
          chk("sb_op", 64'(if_op), 64'(e.instr[31:26]));
        end
      end
    end
    @(posedge clk);
    #1;
    if (imem_resp_valid) imem_resp_valid = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_rd(pend_addr);
      end
    end
  endtask

  task automatic wait_req(input int max);
    int n = 0;
    while (!imem_req_valid && n < max) begin cyc(); n++; end
    if (!imem_req_valid) chk("timeout_req", 64'd0, 64'd1);
  endtask

  task automatic wait_out(input int max);
    int n = 0;
    while (!if_valid && n < max) begin cyc(); n++; end
    if (!if_valid) chk("timeout_out", 64'd0, 64'd1);
  endtask

  // Assert reset between edges and check that the outputs clear without waiting for a clock.
  task automatic reset_check(input string tag);
    rst = 1'b1;
    imem_resp_valid = 1'b0;
    pend_cnt = 0; pend_busy = 1'b0; pend_stale = 1'b0;
    sb.delete();
    #1;
    chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
    chk({tag, "_if_valid"}, 64'(if_valid), 64'd0);
    chk({tag, "_if_instr"}, 64'(if_instr), 64'd0);
    chk({tag, "_if_pc"}, 64'(if_pc), 64'd0);
    chk({tag, "_if_pc4"}, 64'(if_pc_plus4), 64'd0);
    chk({tag, "_addr"}, 64'(imem_req_addr), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc();
    chk({tag, "_boot_req"}, 64'(imem_req_valid), 64'd1);
    chk({tag, "_boot_addr"}, 64'(imem_req_addr), 64'h0);
  endtask

  initial begin
    logic [31:0] snap_instr;
    vecs[0] = '{32'h0000_1000, 32'h0000_1000, 32'h8C22_0004, 1, 0, 6'h23, 32'h0000_1004};
    vecs[1] = '{32'h0000_2002, 32'h0000_2000, 32'h1085_FFFD, 2, 2, 6'h04, 32'h0000_2004};
    vecs[2] = '{32'h0000_3FFF, 32'h0000_3FFC, 32'hAC43_0008, 3, 1, 6'h2B, 32'h0000_4000};
    vecs[3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0000_0020, 1, 0, 6'h00, 32'h0000_0000};
    vecs[4] = '{32'h8000_0010, 32'h8000_0010, 32'hFC00_0000, 4, 3, 6'h3F, 32'h8000_0014};
    mem[32'h0000_0000] = 32'h8C22_0004;
    for (int i = 0; i < 5; i++) mem[vecs[i].pc] = vecs[i].instr;

    rst = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
    branch_taken = 1'b0; branch_target = 32'd0; if_ready = 1'b0;
    lat = 1; pend_cnt = 0; pend_busy = 1'b0; pend_stale = 1'b0; pend_addr = 32'd0;
    #2;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_if_valid", 64'(if_valid), 64'd0);
    chk("rst_addr", 64'(imem_req_addr), 64'h0);
    chk("rst_if_pc4", 64'(if_pc_plus4), 64'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // First fetch: lw at address 0 arrives in the buffer on the third edge after release.
    cyc();
    chk("t1_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t1_addr", 64'(imem_req_addr), 64'h0);
    cyc();
    chk("t1_wait_no_req", 64'(imem_req_valid), 64'd0);
    chk("t1_wait_no_out", 64'(if_valid), 64'd0);
    cyc();
    chk("t1_if_valid", 64'(if_valid), 64'd1);
    chk("t1_if_pc", 64'(if_pc), 64'h0);
    chk("t1_if_op", 64'(if_op), 64'h23);
    chk("t1_if_pc4", 64'(if_pc_plus4), 64'h4);
    chk("t1_if_instr", 64'(if_instr), 64'h8C22_0004);

    // Back-pressure: five stalled cycles with no new request.
    snap_instr = if_instr;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t2_hold_valid", 64'(if_valid), 64'd1);
      chk("t2_hold_noreq", 64'(imem_req_valid), 64'd0);
      chk("t2_hold_instr", 64'(if_instr), 64'(snap_instr));
    end
    if_ready = 1'b1;
    cyc();
    chk("t2_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t2_addr", 64'(imem_req_addr), 64'h4);
    chk("t2_if_valid_low", 64'(if_valid), 64'd0);

    // Fetch 4 normally, then redirect to 0x40 while the fetch of 8 is outstanding.
    cyc(); cyc();
    chk("t3_pc4_valid", 64'(if_valid), 64'd1);
    chk("t3_pc4_pc", 64'(if_pc), 64'h4);
    cyc();
    chk("t3_addr8", 64'(imem_req_addr), 64'h8);
    lat = 3;
    cyc();
    branch_taken = 1'b1; branch_target = 32'h0000_0040;
    cyc();
    branch_taken = 1'b0;
    wait_req(10);
    chk("t3_no_deliver", 64'(if_valid), 64'd0);
    chk("t3_addr40", 64'(imem_req_addr), 64'h40);
    lat = 1;
    wait_out(10);
    chk("t3_if_pc40", 64'(if_pc), 64'h40);
    cyc();

    // Redirect to 0x10, then a redirect to 0x103 that coincides with the accept of 0x10.
    imem_req_ready = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h0000_0010;
    cyc();
    branch_taken = 1'b0;
    chk("t4_addr10", 64'(imem_req_addr), 64'h10);
    imem_req_ready = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h0000_0103;
    cyc();
    branch_taken = 1'b0;
    wait_req(10);
    chk("t4_no_deliver", 64'(if_valid), 64'd0);
    chk("t4_addr100", 64'(imem_req_addr), 64'h100);

    // Flush in HOLD while decode is ready: no transfer takes place.
    wait_out(10);
    chk("t5_if_pc100", 64'(if_pc), 64'h100);
    branch_taken = 1'b1; branch_target = 32'h0000_0200;
    cyc();
    branch_taken = 1'b0;
    chk("t5_flush_valid", 64'(if_valid), 64'd0);
    chk("t5_flush_req", 64'(imem_req_valid), 64'd1);
    chk("t5_addr200", 64'(imem_req_addr), 64'h200);

    // The PC wraps when fetching from the top word of the address space.
    imem_req_ready = 1'b0;
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    cyc();
    branch_taken = 1'b0; imem_req_ready = 1'b1;
    wait_out(10);
    chk("t5_wrap_pc", 64'(if_pc), 64'hFFFF_FFFC);
    chk("t5_wrap_pc4", 64'(if_pc_plus4), 64'h0);
    cyc();
    chk("t5_wrap_addr", 64'(imem_req_addr), 64'h0);

    // Asynchronous reset asserted in WAIT, then in HOLD.
    cyc();
    chk("t6_in_wait", 64'(imem_req_valid), 64'd0);
    reset_check("t6_wait");
    if_ready = 1'b0;
    wait_out(10);
    reset_check("t6_hold");

    // Table of redirect -> fetch vectors with varying latency and back-pressure.
    for (int i = 0; i < 5; i++) begin
      if_ready = 1'b1;
      imem_req_ready = 1'b0;
      branch_taken = 1'b1; branch_target = vecs[i].tgt;
      cyc();
      branch_taken = 1'b0;
      chk("tv_addr", 64'(imem_req_addr), 64'(vecs[i].pc));
      lat = vecs[i].lat; imem_req_ready = 1'b1; if_ready = 1'b0;
      wait_out(20);
      chk("tv_pc", 64'(if_pc), 64'(vecs[i].pc));
      chk("tv_op", 64'(if_op), 64'(vecs[i].op));
      chk("tv_pc4", 64'(if_pc_plus4), 64'(vecs[i].pc4));
      chk("tv_instr", 64'(if_instr), 64'(vecs[i].instr));
      for (int h = 0; h < vecs[i].hold; h++) cyc();
      chk("tv_held", 64'(if_valid), 64'd1);
      if_ready = 1'b1;
      cyc();
      chk("tv_next_addr", 64'(imem_req_addr), 64'(vecs[i].pc4));
    end

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the opcode decoder/control unit.
- Holds the PC and issues single-outstanding requests to instruction memory over a valid/ready request channel with a variable-latency response.
- Presents each fetched instruction, its opcode field and its PC to the decode stage through a one-entry valid/ready output buffer.
- Applies taken-branch (beq) redirects by squashing stale fetches.

Parameters:
- ADDR_W, 32, PC/address width in bits.
- RESET_PC, 0, PC value loaded on reset; must be word-aligned.
- PC_INC, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  ADDR_W  fetch byte address; low 2 bits always 0.
- imem_resp_valid  in  1  response data valid; exactly one response per accepted request, at least 1 cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- branch_taken  in  1  redirect pulse from branch resolution.
- branch_target  in  ADDR_W  redirect address; low 2 bits ignored (forced 0).
- if_valid  out  1  output buffer holds a valid instruction.
- if_ready  in  1  decode stage accepts.
- if_instr  out  32  instruction word.
- if_op  out  6  if_instr[31:26], driven to the control-unit opcode input.
- if_pc  out  ADDR_W  address of if_instr.
- if_pc_plus4  out  ADDR_W  if_pc + PC_INC, modulo 2^ADDR_W.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=BOOT, pc=RESET_PC, drop=0.
  - imem_req_valid=0, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0.
  - imem_req_addr=RESET_PC.
- Reset mid-operation:
  - Any outstanding response is forgotten.
  - Memory must also be reset, so a response after reset is never seen.
- States: BOOT, REQ, WAIT, HOLD. imem_req_valid = (state==REQ). imem_req_addr = pc.
- BOOT -> REQ unconditionally on the next edge. If branch_taken is high in BOOT: pc<=target.
- REQ, no branch_taken:
  - On imem_req_ready: req_pc<=pc, pc<=pc+PC_INC, state->WAIT.
  - Otherwise stay in REQ with pc and address stable.
- REQ, branch_taken:
  - pc<=target in all cases.
  - If imem_req_ready in the same cycle: the accepted request is stale, so drop<=1 and state->WAIT.
  - Otherwise stay in REQ. The address changes only on a redirect.
- WAIT, no resp_valid:
  - If branch_taken: pc<=target, drop<=1.
  - Stay in WAIT.
- WAIT, resp_valid:
  - If drop or branch_taken: discard data, drop<=0, state->REQ. If branch_taken: pc<=target.
  - Otherwise: if_instr<=data, if_pc<=req_pc, if_pc_plus4<=req_pc+PC_INC, if_valid<=1, state->HOLD.
- HOLD:
  - fire = if_valid & if_ready & ~branch_taken.
  - On fire: if_valid<=0, state->REQ.
  - On branch_taken: if_valid<=0 (flush, no transfer), pc<=target, state->REQ.
  - Otherwise hold all outputs stable.
- Output rules:
  - if_instr, if_pc and if_pc_plus4 retain their last values when if_valid=0.
  - if_op is always if_instr[31:26].
- Throughput and latency:
  - At most one request outstanding.
  - Minimum 3 cycles per instruction: REQ, WAIT, HOLD.
  - Fetch latency is req accept -> response, plus 1 cycle to if_valid.
- Arithmetic: all PC adds wrap modulo 2^ADDR_W; 0xFFFFFFFC + 4 = 0x00000000.
- Simultaneous events: branch_taken always has priority over the request handshake, the response, and the output handshake.

Test Plan:
- Reset with RESET_PC=0; memory with ready=1 and 1-cycle latency returns 0x8C220004 (lw) -> if_valid rises on cycle 3 after release, if_pc=0, if_op=6'b100011, if_pc_plus4=4; next imem_req_addr=4.
- Hold if_ready=0 for 5 cycles with if_valid=1 -> outputs stable and no new request (imem_req_valid=0); then if_ready=1 -> REQ with addr=4.
- branch_taken with target 0x40 while in WAIT for addr 8 -> response for 8 discarded (if_valid stays 0), next request addr=0x40, instruction delivered with if_pc=0x40.
- branch_taken with target 0x103 in the same cycle as a request accept for addr 0x10 -> that response dropped, next request addr=0x100.
- branch_taken in HOLD with if_ready=1 -> no transfer counted, if_valid=0 next cycle, fetch resumes at the target; separately, pc=0xFFFFFFFC fetch -> if_pc_plus4=0, next addr=0.
- Assert rst in WAIT and in HOLD -> outputs return to reset values in the same cycle (async); after release, first request addr=RESET_PC.
